comb: RTL and testbench

Multi-stage digital differentiator (comb section), the inverse of the running-sum integrator. Each accepted input sample is passed through `s` cascaded comb stages, each computing `y[k] = x[k] - x[k-d]` in wrapping two's-complement arithmetic. It sits at the decimated-rate end of a CIC chain: integrator → sample-strobe decimation → comb. Modular arithmetic recovers exact results from a wrapped integrator output, as long as `m` is wide enough.

---
 rtl/comb_if.sv | 14 +
 rtl/comb.sv | 52 +++++
 tb/tb_comb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/comb_if.sv
// Sample stream between a decimator and the comb section: strobed input
// sample in, registered output sample with a one-cycle valid pulse out.
interface comb_if #(
  parameter int n = 16,
  parameter int m = 17
);
  logic                ce;
  logic signed [n-1:0] in;
  logic signed [m-1:0] out;
  logic                ovalid;

  modport master (output ce, output in, input out, input ovalid);
  modport slave  (input ce, input in, output out, output ovalid);
endinterface

// File: rtl/comb.sv
// CIC comb section: s cascaded stages of y[k] = x[k] - x[k-d], modulo 2^m.
// Each stage registers its difference and its valid flag.
module comb #(
  parameter int n = 16,
  parameter int m = 17,
  parameter int d = 1,
  parameter int s = 1
) (
  input logic  clk,
  input logic  clr,
  comb_if.slave bus
);

  // x[k]/v[k] is the sample stream entering stage k; x[s]/v[s] is the output
  logic [s:0][m-1:0] x;
  logic [s:0]        v;

  assign x[0] = m'(signed'(bus.in[n-1:0]));
  assign v[0] = bus.ce;

  genvar gi;
  generate
    for (gi = 0; gi < s; gi++) begin : g_stage
      logic [m-1:0] dly_reg [d];
      logic [m-1:0] res_reg;
      logic         vld_reg;

      // delay line only advances on valid samples, so idle gaps are transparent
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          res_reg <= '0;
          vld_reg <= 1'b0;
          for (int i = 0; i < d; i++) dly_reg[i] <= '0;
        end else begin
          vld_reg <= v[gi];
          if (v[gi]) begin
            res_reg    <= x[gi] - dly_reg[d-1];
            dly_reg[0] <= x[gi];
            for (int i = 1; i < d; i++) dly_reg[i] <= dly_reg[i-1];
          end
        end
      end

      assign x[gi+1] = res_reg;
      assign v[gi+1] = vld_reg;
    end
  endgenerate

  assign bus.out    = x[s];
  assign bus.ovalid = v[s];

endmodule

// File: tb/tb_comb.sv
// Directed bench for comb: four configurations driven in sequence, each
// output compared against hand-computed values.
module tb_comb;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  comb_if #(.n(8), .m(8)) i1 ();
  comb_if #(.n(8), .m(8)) i2 ();
  comb_if #(.n(4), .m(8)) i3 ();
  comb_if #(.n(8), .m(8)) i4 ();

  comb #(.n(8), .m(8), .d(1), .s(1)) u1 (.clk(clk), .clr(clr), .bus(i1));
  comb #(.n(8), .m(8), .d(2), .s(2)) u2 (.clk(clk), .clr(clr), .bus(i2));
  comb #(.n(4), .m(8), .d(1), .s(1)) u3 (.clk(clk), .clr(clr), .bus(i3));
  comb #(.n(8), .m(8), .d(1), .s(2)) u4 (.clk(clk), .clr(clr), .bus(i4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
    $display("check %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #1;
    clr = 1'b0;
  endtask

  logic [7:0] exp3 [8];

  initial begin
    i1.ce = 0; i1.in = '0;
    i2.ce = 0; i2.in = '0;
    i3.ce = 0; i3.in = '0;
    i4.ce = 0; i4.in = '0;
    exp3[0] = 8'd5;  exp3[1] = 8'd5;  exp3[2] = 8'hFB; exp3[3] = 8'hFB;
    exp3[4] = 8'd0;  exp3[5] = 8'd0;  exp3[6] = 8'd0;  exp3[7] = 8'd0;

    #2;
    clr = 1'b1;
    #1;
    chk("rst_out",    i1.out,    8'd0);
    chk("rst_ovalid", {7'd0, i1.ovalid}, 8'd0);
    tick();
    clr = 1'b0;

    // s=1, d=1 basic differencing
    i1.ce = 1; i1.in = 8'd10; tick();
    chk("s1_a", i1.out, 8'd10); chk("s1_a_v", {7'd0, i1.ovalid}, 8'd1);
    i1.in = 8'd13; tick();
    chk("s1_b", i1.out, 8'd3);  chk("s1_b_v", {7'd0, i1.ovalid}, 8'd1);
    i1.in = 8'd7; tick();
    chk("s1_c", i1.out, 8'hFA); chk("s1_c_v", {7'd0, i1.ovalid}, 8'd1);
    i1.ce = 0; tick();
    chk("s1_hold", i1.out, 8'hFA); chk("s1_idle_v", {7'd0, i1.ovalid}, 8'd0);

    // wrapped integrator values recover exact differences
    pulse_clr();
    chk("wrap_rst", i1.out, 8'd0);
    i1.ce = 1; i1.in = 8'd120; tick();
    chk("wrap_a", i1.out, 8'd120);
    i1.in = 8'd127; tick();
    chk("wrap_b", i1.out, 8'd7);
    i1.in = 8'h86; tick();
    chk("wrap_c", i1.out, 8'd7);
    i1.ce = 0; tick();

    // d=2, s=2, continuous constant input
    pulse_clr();
    for (int k = 0; k < 8; k++) begin
      i2.ce = 1; i2.in = 8'd5; tick();
      if (k == 0) chk("d2_lag_v", {7'd0, i2.ovalid}, 8'd0);
      else begin
        chk($sformatf("d2_out%0d", k - 1), i2.out, exp3[k-1]);
        chk($sformatf("d2_v%0d", k - 1), {7'd0, i2.ovalid}, 8'd1);
      end
    end
    i2.ce = 0; tick();
    chk("d2_out7", i2.out, exp3[7]); chk("d2_v7", {7'd0, i2.ovalid}, 8'd1);
    tick();
    chk("d2_end_v", {7'd0, i2.ovalid}, 8'd0);

    // same configuration, ce every third clock
    pulse_clr();
    for (int k = 0; k < 8; k++) begin
      i2.ce = 1; i2.in = 8'd5; tick();
      i2.ce = 0;
      chk($sformatf("gap_pre_v%0d", k), {7'd0, i2.ovalid}, 8'd0);
      tick();
      chk($sformatf("gap_out%0d", k), i2.out, exp3[k]);
      chk($sformatf("gap_v%0d", k), {7'd0, i2.ovalid}, 8'd1);
      tick();
      chk($sformatf("gap_hold%0d", k), i2.out, exp3[k]);
      chk($sformatf("gap_post_v%0d", k), {7'd0, i2.ovalid}, 8'd0);
    end

    // sign extension n=4 -> m=8
    pulse_clr();
    i3.ce = 1; i3.in = 4'b1101; tick();
    chk("sext_a", i3.out, 8'hFD);
    i3.in = 4'd7; tick();
    chk("sext_b", i3.out, 8'h0A);
    i3.ce = 0; tick();

    // mid-stream asynchronous clear with samples in flight
    pulse_clr();
    i4.ce = 1; i4.in = 8'd9; tick();
    i4.in = 8'd20; tick();
    chk("mid_pre_v", {7'd0, i4.ovalid}, 8'd1);
    #2;
    clr = 1'b1;
    #1;
    chk("mid_clr_out", i4.out, 8'd0);
    chk("mid_clr_v", {7'd0, i4.ovalid}, 8'd0);
    tick();
    chk("mid_held_out", i4.out, 8'd0);
    chk("mid_held_v", {7'd0, i4.ovalid}, 8'd0);
    clr = 1'b0;
    i4.ce = 0; tick();
    chk("mid_nostale_v", {7'd0, i4.ovalid}, 8'd0);
    tick();
    chk("mid_nostale2_v", {7'd0, i4.ovalid}, 8'd0);
    i4.ce = 1; i4.in = 8'd4; tick();
    chk("mid_lat_v", {7'd0, i4.ovalid}, 8'd0);
    i4.in = 8'd4; tick();
    chk("mid_a", i4.out, 8'd4); chk("mid_a_v", {7'd0, i4.ovalid}, 8'd1);
    i4.ce = 0; tick();
    chk("mid_b", i4.out, 8'hFC); chk("mid_b_v", {7'd0, i4.ovalid}, 8'd1);
    tick();
    chk("mid_end_v", {7'd0, i4.ovalid}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
